// File: rtl/mbisr_repair_ctrl_if.sv
// ---------------------------------------------------------------------------
// mbisr_repair_ctrl_if
// Bundles every non-clock/reset signal of the self-repair controller:
//   - MBIST control:  mbist_active, fail_valid, fail_addr, clear
//   - MBIST port:     b_en, b_we, b_addr, b_wdata -> b_rdata
//   - Functional port: f_en, f_we, f_addr, f_wdata -> f_rdy, f_rdata
//   - Memory port:    mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   - Status:         repair_done, repair_fail, spare_used
// Modport slave is taken by the controller; modport master by its environment
// (MBIST engine, functional requester, memory macro).
// ---------------------------------------------------------------------------
interface mbisr_repair_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              mbist_active;
    logic              fail_valid;
    logic [ADDR_W-1:0] fail_addr;
    logic              clear;

    logic              b_en;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_rdata;

    logic              f_en;
    logic              f_we;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_wdata;
    logic              f_rdy;
    logic [DATA_W-1:0] f_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              repair_done;
    logic              repair_fail;
    logic [3:0]        spare_used;

    modport slave (
        input  mbist_active, fail_valid, fail_addr, clear,
        input  b_en, b_we, b_addr, b_wdata,
        output b_rdata,
        input  f_en, f_we, f_addr, f_wdata,
        output f_rdy, f_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output repair_done, repair_fail, spare_used
    );

    modport master (
        output mbist_active, fail_valid, fail_addr, clear,
        output b_en, b_we, b_addr, b_wdata,
        input  b_rdata,
        output f_en, f_we, f_addr, f_wdata,
        input  f_rdy, f_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  repair_done, repair_fail, spare_used
    );
endinterface

// File: rtl/mbisr_repair_ctrl.sv
// ---------------------------------------------------------------------------
// mbisr_repair_ctrl
// Built-in self-repair controller sitting between the MBIST engine, the
// functional access port and a single-port memory. While MBIST runs a pass
// (mbist_active=1) failing addresses are logged into an NSPARE-entry table;
// afterwards functional accesses to logged words are served from internal
// spare registers instead of the memory.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mbisr_repair_ctrl_if.slave (MBIST port, functional port, memory
//          port, fail log inputs, clear, status outputs)
//
// Optional feature macro: MBISR_RETEST_EN
//   defined   - remap also applies to the MBIST port while the table holds
//               any entry, and a repeated fail on a logged address (faulty
//               spare) sets repair_fail.
//   undefined - MBIST port always sees raw memory; duplicates are ignored.
// ---------------------------------------------------------------------------
module mbisr_repair_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int NSPARE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mbisr_repair_ctrl_if.slave   bus
);
    localparam int IDX_W = (NSPARE > 1) ? $clog2(NSPARE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OK      = 2'd2,
        ST_FAIL    = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic                act_r;
    logic [NSPARE-1:0]   valid_r;
    logic [ADDR_W-1:0]   tag_r   [NSPARE];
    logic [DATA_W-1:0]   spare_r [NSPARE];
    logic                repair_fail_r;
    logic [3:0]          spare_used_r;

    logic                b_rd_r, b_hit_r, f_rd_r, f_hit_r;
    logic [DATA_W-1:0]   b_spare_r, f_spare_r, b_hold_r, f_hold_r;

    logic                rise_s, fall_s, clear_s;
    logic                sel_en_s, sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                hit_s, fail_hit_s, free_ok_s, remap_s, spare_hit_s;
    logic [IDX_W-1:0]    hit_idx_s, free_idx_s;
    logic                log_s, alloc_s, overflow_s, fail_next_s;
    logic                b_rd_s, f_rd_s;
    logic [DATA_W-1:0]   b_rdata_s, f_rdata_s;

    // Edge detection of mbist_active and port selection
    always_comb begin
        rise_s      = bus.mbist_active & ~act_r;
        fall_s      = ~bus.mbist_active & act_r;
        clear_s     = bus.clear & ~bus.mbist_active;
        if (bus.mbist_active) begin
            sel_en_s    = bus.b_en;
            sel_we_s    = bus.b_we;
            sel_addr_s  = bus.b_addr;
            sel_wdata_s = bus.b_wdata;
        end else begin
            sel_en_s    = bus.f_en;
            sel_we_s    = bus.f_we;
            sel_addr_s  = bus.f_addr;
            sel_wdata_s = bus.f_wdata;
        end
    end

    // Table lookups: access hit, fail-address hit, lowest free entry
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = {IDX_W{1'b0}};
        fail_hit_s = 1'b0;
        free_ok_s  = 1'b0;
        free_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < NSPARE; i++) begin
            if (valid_r[i] && (tag_r[i] == sel_addr_s)) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_s     = hit_s;
            end
            if (valid_r[i] && (tag_r[i] == bus.fail_addr)) begin
                fail_hit_s = 1'b1;
            end else begin
                fail_hit_s = fail_hit_s;
            end
        end
        // Scan downward so the last free entry found is the lowest index
        for (int i = NSPARE - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_ok_s  = 1'b1;
                free_idx_s = IDX_W'(i);
            end else begin
                free_ok_s  = free_ok_s;
            end
        end
    end

    // Remap enable, fail logging decisions and memory port drive
    always_comb begin
`ifdef MBISR_RETEST_EN
        if (bus.mbist_active) begin
            remap_s = (spare_used_r != 4'd0);
        end else begin
            remap_s = (state_r == ST_OK) || (state_r == ST_FAIL);
        end
`else
        remap_s = ~bus.mbist_active && ((state_r == ST_OK) || (state_r == ST_FAIL));
`endif
        spare_hit_s = remap_s & hit_s;
        log_s       = (state_r == ST_COLLECT) & bus.fail_valid;
        alloc_s     = log_s & ~fail_hit_s & free_ok_s;
`ifdef MBISR_RETEST_EN
        // A repeat fail on a logged address means the spare itself is bad
        overflow_s  = log_s & (fail_hit_s | ~free_ok_s);
`else
        overflow_s  = log_s & ~fail_hit_s & ~free_ok_s;
`endif
        fail_next_s   = repair_fail_r | overflow_s;
        bus.mem_en    = sel_en_s & ~spare_hit_s;
        bus.mem_we    = sel_we_s & ~spare_hit_s;
        bus.mem_addr  = sel_addr_s;
        bus.mem_wdata = sel_wdata_s;
    end

    // Next-state logic of the repair FSM; clear overrides everything
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_OK, ST_FAIL: begin
                if (rise_s) state_s = ST_COLLECT;
                else        state_s = state_r;
            end
            ST_COLLECT: begin
                // Decision includes a fail logged on this very edge
                if (fall_s) state_s = fail_next_s ? ST_FAIL : ST_OK;
                else        state_s = ST_COLLECT;
            end
            default: state_s = ST_IDLE;
        endcase
        if (clear_s) state_s = ST_IDLE;
        else         state_s = state_s;
    end

    // FSM state and mbist_active history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            act_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            act_r   <= bus.mbist_active;
        end
    end

    // Repair table, spare registers and status counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r       <= {NSPARE{1'b0}};
            repair_fail_r <= 1'b0;
            spare_used_r  <= 4'd0;
            for (int i = 0; i < NSPARE; i++) begin
                tag_r[i]   <= {ADDR_W{1'b0}};
                spare_r[i] <= {DATA_W{1'b0}};
            end
        end else if (clear_s) begin
            valid_r       <= {NSPARE{1'b0}};
            repair_fail_r <= 1'b0;
            spare_used_r  <= 4'd0;
            for (int i = 0; i < NSPARE; i++) begin
                spare_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            repair_fail_r <= fail_next_s;
            if (alloc_s) begin
                valid_r[free_idx_s] <= 1'b1;
                tag_r[free_idx_s]   <= bus.fail_addr;
                spare_r[free_idx_s] <= {DATA_W{1'b0}};
                spare_used_r        <= spare_used_r + 4'd1;
            end
            // Hit requires a valid entry, alloc a free one: never the same index
            if (sel_en_s && sel_we_s && spare_hit_s) begin
                spare_r[hit_idx_s] <= sel_wdata_s;
            end
        end
    end

    // Read-return muxes: registered hit/spare vs memory data, else hold
    always_comb begin
        b_rd_s = bus.mbist_active & bus.b_en & ~bus.b_we;
        f_rd_s = ~bus.mbist_active & bus.f_en & ~bus.f_we;
        if (b_rd_r) b_rdata_s = b_hit_r ? b_spare_r : bus.mem_rdata;
        else        b_rdata_s = b_hold_r;
        if (f_rd_r) f_rdata_s = f_hit_r ? f_spare_r : bus.mem_rdata;
        else        f_rdata_s = f_hold_r;
    end

    // Read pipeline: capture hit and spare contents at the request edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_rd_r    <= 1'b0;
            b_hit_r   <= 1'b0;
            b_spare_r <= {DATA_W{1'b0}};
            b_hold_r  <= {DATA_W{1'b0}};
            f_rd_r    <= 1'b0;
            f_hit_r   <= 1'b0;
            f_spare_r <= {DATA_W{1'b0}};
            f_hold_r  <= {DATA_W{1'b0}};
        end else begin
            b_rd_r    <= b_rd_s;
            b_hit_r   <= b_rd_s & spare_hit_s;
            b_spare_r <= spare_r[hit_idx_s];
            b_hold_r  <= b_rdata_s;
            f_rd_r    <= f_rd_s;
            f_hit_r   <= f_rd_s & spare_hit_s;
            f_spare_r <= spare_r[hit_idx_s];
            f_hold_r  <= f_rdata_s;
        end
    end

    // Status outputs
    always_comb begin
        bus.f_rdy       = ~bus.mbist_active;
        bus.b_rdata     = b_rdata_s;
        bus.f_rdata     = f_rdata_s;
        bus.repair_done = (state_r == ST_OK) || (state_r == ST_FAIL);
        bus.repair_fail = repair_fail_r;
        bus.spare_used  = spare_used_r;
    end

endmodule

// File: tb/tb_mbisr_repair_ctrl.sv
module tb_mbisr_repair_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [7:0] mem_model [32];

    mbisr_repair_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    mbisr_repair_ctrl #(.ADDR_W(5), .DATA_W(8), .NSPARE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory macro model: synchronous write, 1-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem_model[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fail_at(input logic [4:0] a);
        bus.fail_valid = 1'b1;
        bus.fail_addr  = a;
        step();
        bus.fail_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem_model[i] = 8'(i) ^ 8'hC0;
        bus.mem_rdata = 8'h00;
        bus.mbist_active = 1'b0; bus.fail_valid = 1'b0; bus.fail_addr = 5'd0;
        bus.clear = 1'b0;
        bus.b_en = 1'b0; bus.b_we = 1'b0; bus.b_addr = 5'd0; bus.b_wdata = 8'h00;
        bus.f_en = 1'b0; bus.f_we = 1'b0; bus.f_addr = 5'd0; bus.f_wdata = 8'h00;
        step(); step();

        // Reset state
        check("rst_f_rdy", 32'(bus.f_rdy), 32'd1);
        check("rst_done", 32'(bus.repair_done), 32'd0);
        check("rst_fail", 32'(bus.repair_fail), 32'd0);
        check("rst_used", 32'(bus.spare_used), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_f_rdata", 32'(bus.f_rdata), 32'd0);
        check("rst_b_rdata", 32'(bus.b_rdata), 32'd0);
        rst = 1'b0;
        step();

        // Pass without faults
        bus.mbist_active = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("pass_f_rdy", 32'(bus.f_rdy), 32'd0);
        bus.mbist_active = 1'b0;
        step();
        check("ok_done", 32'(bus.repair_done), 32'd1);
        check("ok_fail", 32'(bus.repair_fail), 32'd0);
        check("ok_used", 32'(bus.spare_used), 32'd0);

        // Pass with faults at 3 and 17 (17 twice), port arbitration
        bus.mbist_active = 1'b1;
        step();
        check("collect_done", 32'(bus.repair_done), 32'd0);
        fail_at(5'd3);
        fail_at(5'd17);
        fail_at(5'd17);
        check("dup_used", 32'(bus.spare_used), 32'd2);
        bus.f_en = 1'b1; bus.f_we = 1'b1; bus.f_addr = 5'd9; bus.f_wdata = 8'hFF;
        bus.b_en = 1'b1; bus.b_we = 1'b0; bus.b_addr = 5'd12;
        #1;
        check("arb_f_rdy", 32'(bus.f_rdy), 32'd0);
        check("arb_mem_en", 32'(bus.mem_en), 32'd1);
        check("arb_mem_we", 32'(bus.mem_we), 32'd0);
        check("arb_mem_addr", 32'(bus.mem_addr), 32'd12);
        step();
        bus.f_en = 1'b0; bus.b_en = 1'b0;
        #1;
        check("b_rd12", 32'(bus.b_rdata), 32'h0CC);
        step();
        check("b_hold", 32'(bus.b_rdata), 32'h0CC);
        check("no_f_write9", 32'(mem_model[9]), 32'h0C9);
        bus.mbist_active = 1'b0;
        step();
        check("ok2_done", 32'(bus.repair_done), 32'd1);
        check("ok2_fail", 32'(bus.repair_fail), 32'd0);
        check("ok2_used", 32'(bus.spare_used), 32'd2);

        // Functional remap
        bus.f_en = 1'b1; bus.f_we = 1'b1; bus.f_addr = 5'd17; bus.f_wdata = 8'hA5;
        #1;
        check("hit_wr_mem_en", 32'(bus.mem_en), 32'd0);
        step();
        bus.f_we = 1'b0;
        #1;
        check("hit_rd_mem_en", 32'(bus.mem_en), 32'd0);
        step();
        bus.f_en = 1'b0;
        #1;
        check("hit_rd17", 32'(bus.f_rdata), 32'h0A5);
        check("mem17_untouched", 32'(mem_model[17]), 32'h0D1);
        bus.f_en = 1'b1; bus.f_addr = 5'd4;
        #1;
        check("miss_mem_en", 32'(bus.mem_en), 32'd1);
        check("miss_mem_addr", 32'(bus.mem_addr), 32'd4);
        step();
        bus.f_en = 1'b0;
        #1;
        check("miss_rd4", 32'(bus.f_rdata), 32'h0C4);
        step();
        check("f_hold", 32'(bus.f_rdata), 32'h0C4);
        bus.f_en = 1'b1; bus.f_addr = 5'd3;
        step();
        bus.f_en = 1'b0;
        #1;
        check("spare3_zero", 32'(bus.f_rdata), 32'h000);

        // clear
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check("clr_used", 32'(bus.spare_used), 32'd0);
        check("clr_done", 32'(bus.repair_done), 32'd0);

        // Overflow: five distinct faults
        bus.mbist_active = 1'b1;
        step();
        fail_at(5'd1); fail_at(5'd2); fail_at(5'd3); fail_at(5'd4);
        check("full_used", 32'(bus.spare_used), 32'd4);
        check("full_fail", 32'(bus.repair_fail), 32'd0);
        fail_at(5'd5);
        check("ovf_fail", 32'(bus.repair_fail), 32'd1);
        check("ovf_used", 32'(bus.spare_used), 32'd4);
        bus.mbist_active = 1'b0;
        step();
        check("fail_done", 32'(bus.repair_done), 32'd1);
        check("fail_fail", 32'(bus.repair_fail), 32'd1);
        bus.f_en = 1'b1; bus.f_we = 1'b1; bus.f_addr = 5'd2; bus.f_wdata = 8'h33;
        #1;
        check("fail_hit_mem_en", 32'(bus.mem_en), 32'd0);
        step();
        bus.f_we = 1'b0;
        step();
        bus.f_en = 1'b0;
        #1;
        check("fail_rd2", 32'(bus.f_rdata), 32'h033);
        bus.f_en = 1'b1; bus.f_addr = 5'd5;
        #1;
        check("fail_miss_mem_en", 32'(bus.mem_en), 32'd1);
        bus.f_en = 1'b0;
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;

        // Fail coincident with mbist_active falling
        bus.mbist_active = 1'b1;
        step();
        bus.mbist_active = 1'b0;
        fail_at(5'd9);
        check("coinc_used", 32'(bus.spare_used), 32'd1);
        check("coinc_done", 32'(bus.repair_done), 32'd1);
        check("coinc_fail", 32'(bus.repair_fail), 32'd0);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;

        // Reset mid-pass
        bus.mbist_active = 1'b1;
        step();
        fail_at(5'd6);
        fail_at(5'd7);
        check("mid_used", 32'(bus.spare_used), 32'd2);
        rst = 1'b1;
        bus.mbist_active = 1'b0;
        #1;
        check("midrst_used", 32'(bus.spare_used), 32'd0);
        check("midrst_done", 32'(bus.repair_done), 32'd0);
        step();
        rst = 1'b0;
        bus.mbist_active = 1'b1;
        step();
        bus.mbist_active = 1'b0;
        step();
        check("post_rst_done", 32'(bus.repair_done), 32'd1);
        bus.f_en = 1'b1; bus.f_we = 1'b0; bus.f_addr = 5'd7;
        #1;
        check("post_rst_mem_en", 32'(bus.mem_en), 32'd1);
        bus.f_en = 1'b0;
        step();

`ifdef MBISR_RETEST_EN
        // Retest of a repaired memory through the MBIST port
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        bus.mbist_active = 1'b1;
        step();
        fail_at(5'd3);
        bus.mbist_active = 1'b0;
        step();
        bus.mbist_active = 1'b1;
        step();
        bus.b_en = 1'b1; bus.b_we = 1'b1; bus.b_addr = 5'd3; bus.b_wdata = 8'h5A;
        #1;
        check("rt_wr_mem_en", 32'(bus.mem_en), 32'd0);
        step();
        bus.b_we = 1'b0;
        #1;
        check("rt_rd_mem_en", 32'(bus.mem_en), 32'd0);
        step();
        bus.b_en = 1'b0;
        #1;
        check("rt_b_rdata", 32'(bus.b_rdata), 32'h05A);
        fail_at(5'd3);
        check("rt_fail", 32'(bus.repair_fail), 32'd1);
        bus.mbist_active = 1'b0;
        step();
        check("rt_done", 32'(bus.repair_done), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mbisr_repair_ctrl.md
# mbisr_repair_ctrl

Built-in self-repair controller between the MBIST engine, the functional access port and the 32x8 single-port memory. It arbitrates the shared memory port. During a test pass it logs failing addresses reported by MBIST into a small spare-word table. It then transparently remaps functional accesses to failed words onto internal spare registers, and reports repair success or overflow to the top level.

## Interface
- ADDR_W, 5, memory address width (32 words)
- DATA_W, 8, data width
- NSPARE, 4, number of spare words / table entries (1..8)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- mbist_active  in  1  MBIST owns the memory port; test pass in progress
- fail_valid  in  1  MBIST reports a miscompare this cycle
- fail_addr  in  ADDR_W  failing address, qualified by fail_valid
- clear  in  1  synchronous wipe of repair table; ignored while mbist_active=1
- b_en, b_we  in  1  MBIST port request / write
- b_addr  in  ADDR_W;  b_wdata  in  DATA_W
- b_rdata  out  DATA_W  MBIST read data
- f_en, f_we  in  1  functional port request / write
- f_addr  in  ADDR_W;  f_wdata  in  DATA_W
- f_rdy  out  1  functional port accepted (0 while mbist_active)
- f_rdata  out  DATA_W  functional read data
- mem_en, mem_we  out  1  memory request / write
- mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after read request
- repair_done  out  1  state is OK or FAIL
- repair_fail  out  1  sticky: table overflow (or retest fault, see Configuration)
- spare_used  out  4  number of valid table entries

## Operation
- States: IDLE, COLLECT, OK, FAIL. Reset -> IDLE.
- IDLE/OK/FAIL -> COLLECT on mbist_active rising (sampled at posedge).
- COLLECT -> OK on mbist_active falling when repair_fail=0; -> FAIL otherwise.
- clear (mbist_active=0): table invalidated, spare_used=0, repair_fail=0, state -> IDLE.
- Arbitration: mbist_active=1 selects MBIST port, f_rdy=0, functional requests dropped. mbist_active=0 selects functional port, f_rdy=1, b_* ignored.
- Logging, in COLLECT only: fail_valid with an address already in the table -> no change. A new address with a free entry -> allocated to the lowest free index, spare data cleared to 0, spare_used+1. A new address with the table full -> repair_fail=1, table unchanged.
- Remap applies to functional port when state is OK or FAIL. Table entries remain valid in FAIL.
  - Hit on write: spare register written, mem_en=0.
  - Hit on read: mem_en=0; rdata returns spare contents.
  - Miss: pass-through to memory.
- Without remap (MBIST port, or IDLE): mem_* = selected port's signals combinationally.

## Timing
- Reset values: all outputs 0 except f_rdy=1 (mbist_active low); table invalid, spare regs 0.
- mem_* outputs are combinational from selected port plus table lookup; zero added latency.
- Read latency is 1 cycle on both ports. Hit flag and spare data are registered at the request edge. Next cycle rdata = hit_q ? spare_q : mem_rdata.
- b_rdata/f_rdata hold their last value when no read was issued the previous cycle.
- Allocation takes effect at the edge after fail_valid; a functional access in that same edge cannot occur (port owned by MBIST).
- fail_valid coincident with the mbist_active falling edge is still logged before the state decision.
- Write to a spare and read of the same address next cycle returns the new data.
- rst mid-pass: table, spares and state cleared immediately; no repair survives.

## Configuration
- MBISR_RETEST_EN defined:
  - Remap also applies to the MBIST port whenever the table holds ≥1 valid entry, so a second pass tests the repaired memory.
  - fail_valid on an address already in the table sets repair_fail=1 (spare word itself faulty).
- Undefined:
  - MBIST port always sees raw memory.
  - Duplicate fail addresses are silently ignored.

## Test plan
- Reset, no faults: mbist_active pulse 10 cycles, no fail_valid -> state OK, repair_done=1, repair_fail=0, spare_used=0.
- Faults at 3 and 17 (17 reported twice) -> spare_used=2, OK. f write 0xA5 @17 -> mem_en=0. Read @17 -> f_rdata=0xA5 one cycle later. Read @4 -> mem_rdata passed through.
- Five distinct fault addresses with NSPARE=4 -> repair_fail=1, state FAIL, spare_used=4.
- f_en asserted while mbist_active=1 -> f_rdy=0, mem_* follow b_*, no functional write reaches memory.
- rst asserted mid-COLLECT after 2 allocations -> spare_used=0, state IDLE at once. clear after OK -> spare_used=0, repair_done=0.
- MBISR_RETEST_EN: repaired addr 3, second pass writes/reads 0x5A @3 via b_* -> b_rdata=0x5A with mem_en=0. fail_valid @3 -> repair_fail=1.
